// File: rtl/adc_emulator.sv
// adc_emulator: responder end of the adc_controller serial link. Stands in
// for the camera's serial ADC so the imager datapath can be exercised with
// known pixel values.
//
// Each frame starts on a cs_n fall, which latches one sample from the
// pattern source. The frame is presented MSB first on sdata: LEAD_ZEROS
// zeros, then DATA_BITS of sample, then trailing zeros, for FRAME_BITS bits
// in total. A new bit is driven on every sclk fall, so the controller can
// read it on the following sclk rise.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   sclk, cs_n        serial clock and active-low select from the controller
//                     (asynchronous to clk, synchronized here)
//   mode              pattern select: 0/3 incrementing, 1 constant,
//                     2 checkerboard
//   const_value       constant / checkerboard seed
//   sdata             serial data out, MSB first
//   busy              high while a frame is open
//   conversion_done   one-clk pulse when a frame completes
//   frame_error       one-clk pulse when a frame is aborted early
//   conversion_count  number of completed frames (wraps)
//   last_sample       data field of the last completed frame
module adc_emulator #(
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 4,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic [1:0]           mode,
  input  logic [DATA_BITS-1:0] const_value,
  output logic                 sdata,
  output logic                 busy,
  output logic                 conversion_done,
  output logic                 frame_error,
  output logic [15:0]          conversion_count,
  output logic [DATA_BITS-1:0] last_sample
);

  localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Pattern source: mode 2 alternates the seed and its complement on
  // successive completed frames; modes 0 and 3 both use the counter.
  function automatic logic [DATA_BITS-1:0] pick_sample(
    input logic [1:0]           m,
    input logic [DATA_BITS-1:0] cv,
    input logic [DATA_BITS-1:0] pat,
    input logic                 ph
  );
    logic [DATA_BITS-1:0] s;
    case (m)
      2'd1:    s = cv;
      2'd2:    s = ph ? ~cv : cv;
      default: s = pat;
    endcase
    return s;
  endfunction

  // Input synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // Frame state
  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       rise_cnt_q, rise_cnt_d;
  logic [DATA_BITS-1:0]   sample_q, sample_d;

  // Pattern state and registered outputs
  logic [DATA_BITS-1:0]   pat_q, pat_d;
  logic                   phase_q, phase_d;
  logic                   sdata_q, sdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [15:0]            count_q, count_d;
  logic [DATA_BITS-1:0]   last_q, last_d;

  logic                   sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_BITS-1:0]   sample_sel;
  logic [FRAME_BITS-1:0]  load_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign sample_sel = pick_sample(mode, const_value, pat_q, phase_q);
  // Widening leaves LEAD_ZEROS zeros above the sample; the shift appends
  // the trailing zeros.
  assign load_word  = FRAME_BITS'(sample_sel) << TRAIL;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    rise_cnt_d = rise_cnt_q;
    sample_d   = sample_q;
    pat_d      = pat_q;
    phase_d    = phase_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    count_d    = count_q;
    last_d     = last_q;

    case (state_q)
      S_IDLE: begin
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        if (cs_fall) begin
          shift_d    = load_word;
          sample_d   = sample_sel;
          rise_cnt_d = '0;
          sdata_d    = load_word[FRAME_BITS-1];
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A cs_n edge wins over any sclk edge seen in the same clk.
        if (cs_rise) begin
          sdata_d = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_fall) begin
          // Zero fill means bits beyond the frame come out as 0.
          shift_d = shift_q << 1;
          sdata_d = shift_d[FRAME_BITS-1];
        end else if (sclk_rise) begin
          rise_cnt_d = rise_cnt_q + 1'b1;
          if (rise_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            sdata_d = 1'b0;
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
            last_d  = sample_q;
            pat_d   = pat_q + 1'b1;
            phase_d = ~phase_q;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        sdata_d = 1'b0;
        if (cs_rise) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizers start at the idle line levels so leaving reset
      // never looks like an edge.
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      rise_cnt_q  <= '0;
      sample_q    <= '0;
      pat_q       <= '0;
      phase_q     <= 1'b0;
      sdata_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      last_q      <= '0;
    end else begin
      sclk_sync_q[0] <= sclk;
      cs_sync_q[0]   <= cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      rise_cnt_q  <= rise_cnt_d;
      sample_q    <= sample_d;
      pat_q       <= pat_d;
      phase_q     <= phase_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
      last_q      <= last_d;
    end
  end

  assign sdata            = sdata_q;
  assign busy             = busy_q;
  assign conversion_done  = done_q;
  assign frame_error      = err_q;
  assign conversion_count = count_q;
  assign last_sample      = last_q;

endmodule

// File: tb/tb_adc_emulator.sv
// Directed-plus-random bench for adc_emulator. Acts as the serial master:
// drives cs_n/sclk with slow phases, reads sdata on each sclk rise and
// compares frames, pulses and counters against a frame-level model.
module tb_adc_emulator;

  localparam int FRAME = 16;
  localparam int HALF  = 5;   // clk cycles per sclk phase

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        cs_n;
  logic [1:0]  mode;
  logic [7:0]  const_value;
  logic        sdata;
  logic        busy;
  logic        conversion_done;
  logic        frame_error;
  logic [15:0] conversion_count;
  logic [7:0]  last_sample;

  adc_emulator #(
    .FRAME_BITS (16),
    .LEAD_ZEROS (4),
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sclk            (sclk),
    .cs_n            (cs_n),
    .mode            (mode),
    .const_value     (const_value),
    .sdata           (sdata),
    .busy            (busy),
    .conversion_done (conversion_done),
    .frame_error     (frame_error),
    .conversion_count(conversion_count),
    .last_sample     (last_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int err_seen  = 0;

  // Pulse counters: each clk of a high pulse counts once, so a pulse
  // wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (conversion_done === 1'b1) done_seen++;
    if (frame_error === 1'b1) err_seen++;
  end

  // Frame-level reference model
  int         pat_m;
  bit         phase_m;
  int         count_m;
  logic [7:0] last_m;

  function automatic logic [7:0] model_sample(input logic [1:0] m, input logic [7:0] cv);
    case (m)
      2'd1:    return cv;
      2'd2:    return phase_m ? ~cv : cv;
      default: return 8'(pat_m % 256);
    endcase
  endfunction

  task automatic model_reset();
    pat_m = 0; phase_m = 0; count_m = 0; last_m = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    model_reset();
  endtask

  // endmode: 0 = cs_n rises after the last sclk cycle,
  //          1 = reset asserted instead of cs_n rise,
  //          2 = cs_n rises together with the last sclk rise.
  task automatic run_frame(input int rises, input int extra, input int endmode,
                           output logic [15:0] bits);
    logic [1:0] m0;
    logic [7:0] c0;
    bits = '0;
    m0 = mode; c0 = const_value;
    cs_n = 1'b0;
    wait_clk(HALF);
    // Inputs are latched at cs_n fall; scrambling them now must not matter.
    mode = 2'($urandom);
    const_value = 8'($urandom);
    for (int i = 0; i < rises + extra; i++) begin
      if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
      if (i < FRAME) bits[FRAME-1-i] = sdata;
      else check("extra_sdata_zero", 32'(sdata), 32'd0);
      sclk = 1'b1;
      if (endmode == 2 && i == rises + extra - 1) cs_n = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    if (endmode == 1) begin
      reset = 1'b1; cs_n = 1'b1;
      wait_clk(2);
      reset = 1'b0;
    end else begin
      cs_n = 1'b1;
    end
    wait_clk(HALF);
    mode = m0; const_value = c0;
  endtask

  task automatic frame_check(input int rises, input int extra, input int endmode);
    logic [7:0]  s;
    logic [15:0] word, bits, mask;
    int d0, e0, pres;
    s    = model_sample(mode, const_value);
    word = {4'b0000, s, 4'b0000};
    d0 = done_seen; e0 = err_seen;
    run_frame(rises, extra, endmode, bits);
    pres = (rises + extra > FRAME) ? FRAME : rises + extra;
    mask = 16'hFFFF << (FRAME - pres);
    check("frame_bits", 32'(bits & mask), 32'(word & mask));
    if (endmode == 1) begin
      model_reset();
      check("reset_no_done", 32'(done_seen - d0), 32'd0);
      check("reset_no_error", 32'(err_seen - e0), 32'd0);
    end else if (endmode == 0 && rises >= FRAME) begin
      check("done_pulses", 32'(done_seen - d0), 32'd1);
      check("no_error", 32'(err_seen - e0), 32'd0);
      count_m = (count_m + 1) % 65536;
      last_m  = s;
      pat_m   = (pat_m + 1) % 256;
      phase_m = ~phase_m;
    end else begin
      check("abort_no_done", 32'(done_seen - d0), 32'd0);
      check("abort_error", 32'(err_seen - e0), 32'd1);
    end
    check("count", 32'(conversion_count), 32'(count_m));
    check("last_sample", 32'(last_sample), 32'(last_m));
    check("busy_idle", 32'(busy), 32'd0);
    check("sdata_idle", 32'(sdata), 32'd0);
  endtask

  initial begin
    logic [15:0] b;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1;
    mode = 2'd1; const_value = 8'hA5;
    model_reset();
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);

    // Reset state
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(conversion_done), 32'd0);
    check("rst_error", 32'(frame_error), 32'd0);
    check("rst_count", 32'(conversion_count), 32'd0);
    check("rst_last", 32'(last_sample), 32'd0);

    // Constant 0xA5: literal frame image and counters
    run_frame(16, 0, 0, b);
    check("t1_word", 32'(b), 32'h0A50);
    check("t1_done", 32'(done_seen), 32'd1);
    check("t1_last", 32'(last_sample), 32'hA5);
    check("t1_count", 32'(conversion_count), 32'd1);
    count_m = 1; last_m = 8'hA5; pat_m = 1; phase_m = 1;

    // Incrementing pattern across the 8-bit wrap
    do_reset();
    mode = 2'd0;
    for (int i = 0; i < 300; i++) frame_check(16, 0, 0);
    check("t2_count300", 32'(conversion_count), 32'd300);
    check("t2_last", 32'(last_sample), 32'h2B);

    // Abort after 7 rises, then the same value must repeat
    frame_check(7, 0, 0);
    frame_check(16, 0, 0);
    check("t4_repeat", 32'(last_sample), 32'h2C);

    // cs_n rise coincident with the 16th sclk rise: cs_n wins, frame aborts
    frame_check(16, 0, 2);

    // Reset mid-frame after 9 rises; next frame starts from 0
    frame_check(9, 0, 1);
    frame_check(16, 0, 0);
    check("t5_first_after_reset", 32'(last_sample), 32'h00);

    // Checkerboard from a fresh reset
    do_reset();
    mode = 2'd2; const_value = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      frame_check(16, 0, 0);
      check("t3_checker", 32'(last_sample), (i % 2 == 0) ? 32'h0F : 32'hF0);
    end

    // Extra sclk cycles after a complete frame
    mode = 2'd3;
    frame_check(16, 3, 0);

    // Random frames: mode, seed, abort point and trailing cycles
    for (int i = 0; i < 24; i++) begin
      mode = 2'($urandom_range(0, 3));
      const_value = 8'($urandom);
      if ($urandom_range(0, 3) == 0) frame_check($urandom_range(1, 15), 0, 0);
      else frame_check(16, $urandom_range(0, 2), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
Synthesizable stand-in for the camera's serial ADC. It is the responder end of the adc_controller serial link: it watches sclk/cs_n and shifts out 16-bit conversion frames on sdata. Samples come from a programmable pattern source. It lets the imager datapath (stonyman → adc_controller → pixel FIFO → APB) be brought up and regressed with known pixel values, without a sensor.

Parameters:
FRAME_BITS, 16, sclk rising edges per complete conversion
LEAD_ZEROS, 4, zero bits preceding the data field
DATA_BITS, 8, sample width; FRAME_BITS-LEAD_ZEROS-DATA_BITS trailing zeros follow (must be ≥0)
SYNC_STAGES, 2, flops on sclk/cs_n before edge detection (≥1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sclk  in  1  serial clock from adc_controller
cs_n  in  1  active-low chip select from adc_controller
mode  in  2  pattern select: 0 incrementing, 1 constant, 2 checkerboard, 3 = same as 0
const_value  in  DATA_BITS  constant/checkerboard seed
sdata  out  1  serial data to adc_controller, MSB first
busy  out  1  high while a frame is in progress (cs_n low, synchronized)
conversion_done  out  1  one-clk pulse on completed frame
frame_error  out  1  one-clk pulse on aborted frame
conversion_count  out  16  completed frames, wraps at 0xFFFF→0
last_sample  out  DATA_BITS  data field of last completed frame

Behaviour:
- Reset: sdata=0, busy=0, conversion_done=0, frame_error=0, conversion_count=0, last_sample=0, pattern counter=0, checkerboard phase=0, state IDLE. Sync flops are loaded with idle levels: sclk=0, cs_n=1. Reset mid-frame aborts the frame with no error pulse.
- Edge detection:
  - Edges are detected on synchronized sclk/cs_n (prev vs current).
  - sdata reacts SYNC_STAGES+1 clk after a pin edge.
  - Constraint: sclk high and low phases each ≥ SYNC_STAGES+2 clk.
- Sample select, at cs_n fall:
  - mode 0/3: pattern counter.
  - mode 1: const_value.
  - mode 2: const_value when phase=0, ~const_value when phase=1.
- State IDLE:
  - sdata=0, busy=0.
  - On cs_n fall: load shift = {LEAD_ZEROS'0, sample, trailing zeros}, rise_cnt=0, sdata=shift MSB, busy=1, go SHIFT.
- State SHIFT:
  - Each sclk fall: shift left, sdata=next bit.
  - Each sclk rise: rise_cnt++.
  - Once all FRAME_BITS bits have been presented, further falls drive sdata=0.
  - When rise_cnt reaches FRAME_BITS: go DONE and pulse conversion_done.
  - In the same clk as that pulse: last_sample=sample, conversion_count++, pattern counter++ (wraps at 2^DATA_BITS), checkerboard phase toggles.
- State DONE:
  - sdata=0; extra sclk edges are ignored.
  - On cs_n rise: go IDLE, busy=0, no pulse.
- Abort: cs_n rise in SHIFT with rise_cnt<FRAME_BITS:
  - Pulse frame_error and return to IDLE.
  - Counters, last_sample and phase are unchanged, so the next frame repeats the same sample.
- Simultaneous events:
  - A cs_n edge seen in the same clk as an sclk edge takes priority; that sclk edge is ignored.
  - cs_n fall while busy cannot occur (cs_n is already low). Glitches shorter than one clk are not guaranteed to be seen.
- mode/const_value are sampled only at cs_n fall; changes mid-frame have no effect until the next frame.
- Output timing: all outputs are registered; conversion_done and frame_error are exactly one clk wide.

Test Plan:
1. Reset, mode=1, const_value=0xA5, one 16-sclk frame → bits read on sclk rise = 0000_1010_0101_0000; conversion_done pulses once; last_sample=0xA5; conversion_count=1.
2. mode=0, 300 back-to-back frames → data fields 0x00,0x01,…,0xFF,0x00,…,0x2B; conversion_count=300.
3. mode=2, const_value=0x0F, 4 frames → 0x0F,0xF0,0x0F,0xF0.
4. mode=0, cs_n rises after 7 sclk rises → frame_error pulse, no conversion_done, conversion_count unchanged; next full frame returns the same value as the aborted one.
5. Assert reset after 9 sclk rises mid-frame → sdata=0, busy=0, all counters 0, no error pulse; next frame yields 0x00.
6. Full frame plus 3 extra sclk cycles before cs_n rises → sdata=0 during the extras, exactly one conversion_done, count +1; also run adc_controller connected back-to-back and check its fifo_write_data matches last_sample.
